// File: rtl/get_legendre_segment_div_seq_39s_19s_24_pkg.sv
// Shared widths, saturation limits and FSM encoding for the Legendre
// segment sequential divider.
package legendre_div_pkg;

  localparam int DIVIDEND_W = 39;
  localparam int DIVISOR_W  = 19;
  localparam int QUOT_W     = 24;
  localparam int ITERATIONS = DIVIDEND_W;
  localparam int CNT_W      = $clog2(ITERATIONS);

  localparam logic signed [QUOT_W-1:0] QUOT_MAX = {1'b0, {(QUOT_W-1){1'b1}}};
  localparam logic signed [QUOT_W-1:0] QUOT_MIN = {1'b1, {(QUOT_W-1){1'b0}}};

  // Largest quotient magnitudes that still fit for each result sign
  localparam logic [DIVIDEND_W-1:0] POS_MAG_MAX = {{(DIVIDEND_W-QUOT_W){1'b0}}, QUOT_MAX};
  localparam logic [DIVIDEND_W-1:0] NEG_MAG_MAX = {{(DIVIDEND_W-QUOT_W){1'b0}}, QUOT_MIN};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/get_legendre_segment_div_seq_39s_19s_24_if.sv
// Request/result bundle of the divider: operands and start/ce in, quotient,
// remainder and status flags out.
interface get_legendre_segment_div_seq_39s_19s_24_if;
  import legendre_div_pkg::*;

  logic                          ce;
  logic                          start;
  logic signed [DIVIDEND_W-1:0]  din0;
  logic signed [DIVISOR_W-1:0]   din1;
  logic                          ready;
  logic                          done;
  logic signed [QUOT_W-1:0]      dout;
  logic signed [DIVISOR_W-1:0]   rem;
  logic                          overflow;
  logic                          div_by_zero;

  modport master (
    output ce, start, din0, din1,
    input  ready, done, dout, rem, overflow, div_by_zero
  );

  modport slave (
    input  ce, start, din0, din1,
    output ready, done, dout, rem, overflow, div_by_zero
  );

endinterface

// File: rtl/get_legendre_segment_div_seq_39s_19s_24_sat.sv
// Sign restore and quotient saturation applied to the unsigned core result
// in the final FSM state.
module legendre_div_sat
  import legendre_div_pkg::*;
(
  input  logic [DIVIDEND_W-1:0]        i_quo_mag,
  input  logic [DIVISOR_W-1:0]         i_rem_mag,
  input  logic                         i_neg_quo,
  input  logic                         i_neg_rem,
  input  logic                         i_div_zero,
  output logic signed [QUOT_W-1:0]     o_dout,
  output logic signed [DIVISOR_W-1:0]  o_rem,
  output logic                         o_overflow
);

  logic [QUOT_W-1:0] w_quo_low;
  assign w_quo_low = i_quo_mag[QUOT_W-1:0];

  always_comb begin
    o_dout     = '0;
    o_rem      = '0;
    o_overflow = 1'b0;
    if (i_div_zero) begin
      // Zero divisor: saturate toward the dividend sign, no overflow flag
      o_dout = i_neg_rem ? QUOT_MIN : QUOT_MAX;
    end else begin
      if (i_neg_quo) begin
        if (i_quo_mag > NEG_MAG_MAX) begin
          o_dout     = QUOT_MIN;
          o_overflow = 1'b1;
        end else begin
          // Magnitude 2^(QUOT_W-1) negates onto QUOT_MIN exactly
          o_dout = ~w_quo_low + {{(QUOT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        if (i_quo_mag > POS_MAG_MAX) begin
          o_dout     = QUOT_MAX;
          o_overflow = 1'b1;
        end else begin
          o_dout = w_quo_low;
        end
      end
      o_rem = i_neg_rem ? (~i_rem_mag + {{(DIVISOR_W-1){1'b0}}, 1'b1}) : i_rem_mag;
    end
  end

endmodule

// File: rtl/get_legendre_segment_div_seq_39s_19s_24.sv
// Sequential signed divider 39s / 19s -> saturated 24s quotient plus remainder,
// radix-2 restoring, one quotient bit per enabled cycle.
module get_legendre_segment_div_seq_39s_19s_24
  import legendre_div_pkg::*;
(
  input  logic clk,
  input  logic reset,
  get_legendre_segment_div_seq_39s_19s_24_if.slave bus
);

  state_t                        r_state;
  logic                          r_neg_dvd;
  logic                          r_neg_dvs;
  logic [DIVIDEND_W-1:0]         r_dvd;
  logic [DIVIDEND_W-1:0]         r_quo;
  logic [DIVISOR_W-1:0]          r_dvs;
  logic [DIVISOR_W:0]            r_part;
  logic [CNT_W-1:0]              r_cnt;
  logic                          r_ready;
  logic                          r_done;
  logic signed [QUOT_W-1:0]      r_dout;
  logic signed [DIVISOR_W-1:0]   r_rem;
  logic                          r_overflow;
  logic                          r_div_by_zero;

  logic [DIVIDEND_W-1:0]         w_din0_u;
  logic [DIVISOR_W-1:0]          w_din1_u;
  logic [DIVIDEND_W-1:0]         w_abs0;
  logic [DIVISOR_W-1:0]          w_abs1;
  logic [DIVISOR_W+1:0]          w_shift;
  logic [DIVISOR_W:0]            w_diff;
  logic                          w_ge;
  logic [DIVISOR_W:0]            w_part_next;
  logic                          w_div_zero;
  logic signed [QUOT_W-1:0]      w_sat_dout;
  logic signed [DIVISOR_W-1:0]   w_sat_rem;
  logic                          w_sat_ovf;

  // Magnitudes are unsigned so the most negative operands stay representable
  assign w_din0_u = bus.din0;
  assign w_din1_u = bus.din1;
  assign w_abs0   = w_din0_u[DIVIDEND_W-1] ? (~w_din0_u + {{(DIVIDEND_W-1){1'b0}}, 1'b1}) : w_din0_u;
  assign w_abs1   = w_din1_u[DIVISOR_W-1]  ? (~w_din1_u + {{(DIVISOR_W-1){1'b0}}, 1'b1})  : w_din1_u;

  assign w_shift     = {r_part, r_dvd[DIVIDEND_W-1]};
  assign w_ge        = (w_shift >= {2'b00, r_dvs});
  assign w_diff      = w_shift[DIVISOR_W:0] - {1'b0, r_dvs};
  assign w_part_next = w_ge ? w_diff : w_shift[DIVISOR_W:0];
  assign w_div_zero  = (r_dvs == '0);

  legendre_div_sat u_sat (
    .i_quo_mag  (r_quo),
    .i_rem_mag  (r_part[DIVISOR_W-1:0]),
    .i_neg_quo  (r_neg_dvd ^ r_neg_dvs),
    .i_neg_rem  (r_neg_dvd),
    .i_div_zero (w_div_zero),
    .o_dout     (w_sat_dout),
    .o_rem      (w_sat_rem),
    .o_overflow (w_sat_ovf)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_neg_dvd     <= 1'b0;
      r_neg_dvs     <= 1'b0;
      r_dvd         <= '0;
      r_quo         <= '0;
      r_dvs         <= '0;
      r_part        <= '0;
      r_cnt         <= '0;
      r_ready       <= 1'b1;
      r_done        <= 1'b0;
      r_dout        <= '0;
      r_rem         <= '0;
      r_overflow    <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else if (bus.ce) begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_neg_dvd <= w_din0_u[DIVIDEND_W-1];
            r_neg_dvs <= w_din1_u[DIVISOR_W-1];
            r_dvd     <= w_abs0;
            r_dvs     <= w_abs1;
            r_quo     <= '0;
            r_part    <= '0;
            r_cnt     <= '0;
            r_ready   <= 1'b0;
            r_state   <= CALC;
          end
        end
        CALC: begin
          r_part <= w_part_next;
          r_quo  <= {r_quo[DIVIDEND_W-2:0], w_ge};
          r_dvd  <= {r_dvd[DIVIDEND_W-2:0], 1'b0};
          r_cnt  <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          if (r_cnt == CNT_W'(ITERATIONS - 1)) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_dout        <= w_sat_dout;
          r_rem         <= w_sat_rem;
          r_overflow    <= w_sat_ovf;
          r_div_by_zero <= w_div_zero;
          r_done        <= 1'b1;
          r_ready       <= 1'b1;
          r_state       <= IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready       = r_ready;
  assign bus.done        = r_done;
  assign bus.dout        = r_dout;
  assign bus.rem         = r_rem;
  assign bus.overflow    = r_overflow;
  assign bus.div_by_zero = r_div_by_zero;

endmodule
